// File: rtl/oka_seq_mult.sv
// oka_seq_mult: sequential GF(2) polynomial multiplier, even/odd Karatsuba split
// on one shared N/2-bit carry-less core over three cycles. Option macro: OKA_SEQ_ZERO_SKIP_EN.

module oka_seq_clmul #(
    parameter int W = 3
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-2:0] p_o
);
    always_comb begin
        p_o = '0;
        for (int i = 0; i < W; i++) begin
            if (b_i[i]) begin
                p_o = p_o ^ ({{(W-1){1'b0}}, a_i} << i);
            end
        end
    end
endmodule

module oka_seq_mult #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y,
    output logic           busy
);
    localparam int H  = N / 2;
    localparam int PW = N - 1;   // width of an H x H carry-less product

    generate
        if (N < 4 || (N % 2) != 0) begin : g_bad_n
            $error("oka_seq_mult: N must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [PW-1:0]  p1_q, p1_d, p2_q, p2_d;
    logic [2*N-2:0] y_q, y_d;

    logic [H-1:0]   ae, ao, be, bo;
    logic [H-1:0]   sm_a, sm_b;
    logic [PW-1:0]  sm_p;
    logic [2*N-2:0] y_comb;
    logic           accept;

    // Spread a product onto even powers: p(x) -> p(x^2).
    function automatic logic [2*N-2:0] spread(input logic [PW-1:0] p);
        logic [2*N-2:0] r;
        r = '0;
        for (int i = 0; i < PW; i++) begin
            r[2*i] = p[i];
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < H; gi++) begin : g_split
            assign ae[gi] = a_q[2*gi];
            assign ao[gi] = a_q[2*gi+1];
            assign be[gi] = b_q[2*gi];
            assign bo[gi] = b_q[2*gi+1];
        end
    endgenerate

    always_comb begin
        sm_a = '0;
        sm_b = '0;
        case (state_q)
            MUL1: begin
                sm_a = ae;
                sm_b = be;
            end
            MUL2: begin
                sm_a = ao;
                sm_b = bo;
            end
            MUL3: begin
                sm_a = ae ^ ao;
                sm_b = be ^ bo;
            end
            default: begin
                sm_a = '0;
                sm_b = '0;
            end
        endcase
    end

    oka_seq_clmul #(.W(H)) u_core (
        .a_i (sm_a),
        .b_i (sm_b),
        .p_o (sm_p)
    );

    // In MUL3 the core output is P3, so the middle term uses it directly.
    assign y_comb = spread(p1_q)
                  ^ (spread(p1_q ^ p2_q ^ sm_p) << 1)
                  ^ (spread(p2_q) << 2);

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = MUL1;
            end
            MUL1: begin
                p1_d    = sm_p;
                state_d = MUL2;
            end
            MUL2: begin
                p2_d    = sm_p;
                state_d = MUL3;
            end
            MUL3: begin
                y_d     = y_comb;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = in_valid ? MUL1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d = a;
            b_d = b;
`ifdef OKA_SEQ_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
                state_d = DONE;
                y_d     = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            y_q     <= y_d;
        end
    end
endmodule

// File: doc/oka_seq_mult.md
OKA_SEQ_MULT -- requirements
Module: oka_seq_mult

Interface
REQ-001 SHALL have parameter N, default 6, operand width in bits; SHALL be even and >= 4, with an elaboration-time error otherwise.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a/b present.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-006 SHALL have port a, input, N bits: GF(2) polynomial operand; bit i is the x^i coefficient.
REQ-007 SHALL have port b, input, N bits: GF(2) polynomial operand.
REQ-008 SHALL have port out_valid, output, 1 bit: y holds a completed product.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts y.
REQ-010 SHALL have port y, output, 2N-1 bits: carry-less product a*b over GF(2).
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL compute y = a*b over GF(2), with no reduction and no carries.
REQ-013 SHALL use the even/odd split: ae/be = even-index bits, ao/bo = odd-index bits, each N/2 wide.
REQ-014 SHALL form P1=ae*be, P2=ao*bo, P3=(ae^ao)*(be^bo); y = P1(x^2) ^ x*(P1^P2^P3)(x^2) ^ x^2*P2(x^2).
REQ-015 SHALL instantiate exactly one combinational N/2-bit carry-less sub-multiplier and reuse it over three cycles.
REQ-016 SHALL implement FSM states IDLE, MUL1 (P1), MUL2 (P2), MUL3 (P3 plus final combine), DONE.
REQ-017 SHALL transition IDLE->MUL1 on in_valid&&in_ready, registering a and b; then MUL1->MUL2->MUL3->DONE unconditionally.
REQ-018 SHALL hold DONE until out_valid&&out_ready; it then goes to MUL1 if in_valid (back-to-back accept), else IDLE.
REQ-019 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-020 SHALL drive out_valid high only in DONE; y is loaded on the MUL3->DONE edge.
REQ-021 SHALL keep y stable while out_valid && !out_ready; y retains its last value after the handshake until the next load.
REQ-022 SHALL ignore a/b changes after acceptance.
REQ-023 SHALL have latency of 4 cycles from the accept edge to out_valid high; sustained throughput is one product per 4 cycles.
REQ-024 SHALL ignore in_valid outside in_ready cycles, with no state change.

Reset
REQ-025 SHALL, when rst is high at a clock edge, set state=IDLE, out_valid=0, busy=0, y=0, and clear the operand and partial-product registers.
REQ-026 SHALL give rst priority over every handshake; reset mid-operation (MUL1..DONE) discards the product, and no out_valid follows.
REQ-027 SHALL drive in_ready high in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL use macro OKA_SEQ_ZERO_SKIP_EN.
REQ-029 SHALL, when OKA_SEQ_ZERO_SKIP_EN is defined and accepted a==0 or b==0: go IDLE/DONE->DONE directly with y=0; latency 1 cycle; the sub-multiplier is not exercised.
REQ-030 SHALL, when OKA_SEQ_ZERO_SKIP_EN is undefined, route all operands through MUL1..MUL3; a zero operand yields y=0 after 4 cycles.

Verification
REQ-031 SHALL cover: N=6, a=6'h03, b=6'h03, out_ready=1 -> out_valid 4 cycles after accept, y=11'h005.
REQ-032 SHALL cover: N=6, a=6'h3F, b=6'h3F -> y=11'h555; out_ready held 0 for 3 cycles -> y and out_valid stable, in_ready=0.
REQ-033 SHALL cover: back-to-back: in_valid held with new operands while DONE&&out_ready -> accepted same cycle, next out_valid exactly 4 cycles later, no IDLE cycle.
REQ-034 SHALL cover: rst pulsed in MUL2 -> next cycle IDLE, out_valid=0, y=0, in_ready=1; no stale result appears.
REQ-035 SHALL cover: a=0, b=6'h2A -> y=0 after 1 cycle with OKA_SEQ_ZERO_SKIP_EN, after 4 cycles without.
REQ-036 SHALL cover: N=94, 10^4 random operand pairs with random out_ready stalls -> every y matches a golden carry-less product, with order preserved.
